// File: rtl/sys_cntr_rx.sv
// Receive-side system controller: decodes UART command frames into register-file
// writes/reads and ALU starts, then waits (bounded) for the matching completion.
module sys_cntr_rx #(
  parameter int width      = 8,
  parameter int addr_width = 4,
  parameter int timeout    = 255
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [width-1:0]      Rx_Data,
  input  logic                  Rx_valid,
  input  logic                  Busy,
  input  logic                  Rd_valid,
  input  logic                  ALU_out_valid,
  output logic [addr_width-1:0] Address,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [width-1:0]      WrData,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  CLK_EN,
  output logic                  Err
);

  localparam logic [width-1:0] CMD_WR     = width'(8'hAA);
  localparam logic [width-1:0] CMD_RD     = width'(8'hBB);
  localparam logic [width-1:0] CMD_ALU_OP = width'(8'hCC);
  localparam logic [width-1:0] CMD_ALU    = width'(8'hDD);
  localparam logic [7:0]       TMO_LAST   = 8'(timeout - 1);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_ISSUE, RD_WAIT,
    OP_A, OP_B, FUN, ALU_ISSUE, ALU_WAIT
  } state_t;

  state_t           state;
  logic [7:0]       cnt;
  logic             rx_vld_p0;
  logic [width-1:0] rx_data_p0;

  // Stage p0: input byte register, gives the one-cycle command-to-strobe latency
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) rx_vld_p0 <= 1'b0;
    else        rx_vld_p0 <= Rx_valid;
  end

  always_ff @(posedge CLK) begin
    rx_data_p0 <= Rx_Data;
  end

  // Stage p1: frame FSM with registered strobes
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state   <= IDLE;
      cnt     <= '0;
      Address <= '0;
      WrData  <= '0;
      ALU_FUN <= '0;
      WrEn    <= 1'b0;
      RdEn    <= 1'b0;
      ALU_EN  <= 1'b0;
      CLK_EN  <= 1'b0;
      Err     <= 1'b0;
    end else begin
      WrEn   <= 1'b0;
      RdEn   <= 1'b0;
      ALU_EN <= 1'b0;
      Err    <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_vld_p0) begin
            case (rx_data_p0)
              CMD_WR:     state <= WR_ADDR;
              CMD_RD:     state <= RD_ADDR;
              CMD_ALU_OP: state <= OP_A;
              CMD_ALU:    state <= FUN;
              default:    Err   <= 1'b1;
            endcase
          end
        end
        WR_ADDR: begin
          if (rx_vld_p0) begin
            Address <= rx_data_p0[addr_width-1:0];
            state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (rx_vld_p0) begin
            WrData <= rx_data_p0;
            WrEn   <= 1'b1;
            state  <= IDLE;
          end
        end
        RD_ADDR: begin
          if (rx_vld_p0) begin
            Address <= rx_data_p0[addr_width-1:0];
            state   <= RD_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (rx_vld_p0) Err <= 1'b1;
          if (!Busy) begin
            RdEn  <= 1'b1;
            cnt   <= '0;
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rx_vld_p0) Err <= 1'b1;
          // Completion takes priority over a simultaneous expiry
          if (Rd_valid) begin
            state <= IDLE;
          end else if (cnt == TMO_LAST) begin
            Err   <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        OP_A: begin
          if (rx_vld_p0) begin
            Address <= '0;
            WrData  <= rx_data_p0;
            WrEn    <= 1'b1;
            state   <= OP_B;
          end
        end
        OP_B: begin
          if (rx_vld_p0) begin
            Address <= addr_width'(1);
            WrData  <= rx_data_p0;
            WrEn    <= 1'b1;
            state   <= FUN;
          end
        end
        FUN: begin
          if (rx_vld_p0) begin
            ALU_FUN <= rx_data_p0[3:0];
            state   <= ALU_ISSUE;
          end
        end
        ALU_ISSUE: begin
          if (rx_vld_p0) Err <= 1'b1;
          if (!Busy) begin
            CLK_EN <= 1'b1;
            ALU_EN <= 1'b1;
            cnt    <= '0;
            state  <= ALU_WAIT;
          end
        end
        ALU_WAIT: begin
          if (rx_vld_p0) Err <= 1'b1;
          if (ALU_out_valid) begin
            CLK_EN <= 1'b0;
            state  <= IDLE;
          end else if (cnt == TMO_LAST) begin
            CLK_EN <= 1'b0;
            Err    <= 1'b1;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sys_cntr_rx.md
Name: sys_cntr_rx

Overview:
- Receive-side system controller. Consumes command bytes from the UART receiver and sequences register-file writes/reads and ALU operations.
- Results are returned by the transmit-side controller; this block only issues requests and waits for completion.
- Sits between the Rx data synchroniser and the Reg_File/ALU pair.

Parameters:
- width, 8, data/byte width
- addr_width, 4, register-file address width
- timeout, 255, max cycles waiting for Rd_valid/ALU_out_valid before abort (counter width 8)

Ports:
- CLK  input  1  system clock
- Reset  input  1  asynchronous active-low reset
- Rx_Data  input  width  received byte, valid while Rx_valid high
- Rx_valid  input  1  one-cycle pulse per received byte (already synchronised)
- Busy  input  1  transmitter busy; blocks read/ALU issue
- Rd_valid  input  1  Reg_File read data valid
- ALU_out_valid  input  1  ALU result valid
- Address  output  addr_width  Reg_File address
- WrEn  output  1  Reg_File write strobe, one-cycle pulse
- RdEn  output  1  Reg_File read strobe, one-cycle pulse
- WrData  output  width  Reg_File write data
- ALU_EN  output  1  ALU start, one-cycle pulse
- ALU_FUN  output  4  ALU function code
- CLK_EN  output  1  ALU clock-gate enable
- Err  output  1  one-cycle error pulse

Behaviour:
- Interface: one clock, CLK. Reset is asynchronous and active-low, named Reset. Reset low → all outputs 0, state IDLE, timeout counter 0.
- Reset asserted mid-operation aborts immediately; no strobe is issued after release.
- All outputs are registered. A strobe caused by a byte sampled at edge N is high during the cycle after edge N+1 (one-cycle latency).
- Command bytes:
  - 0xAA: RF write, frame = cmd, addr, data.
  - 0xBB: RF read, frame = cmd, addr.
  - 0xCC: ALU with operands, frame = cmd, A, B, fun.
  - 0xDD: ALU without operands, frame = cmd, fun.
- Address and WrData take only the low addr_width and width bits respectively.
- States and transitions:
  - IDLE:
    - Rx_valid with 0xAA → WR_ADDR.
    - 0xBB → RD_ADDR.
    - 0xCC → OP_A.
    - 0xDD → FUN.
    - Any other byte → Err pulse, stay IDLE.
  - WR_ADDR: on Rx_valid latch Address → WR_DATA.
  - WR_DATA: on Rx_valid latch WrData, pulse WrEn → IDLE.
  - RD_ADDR: on Rx_valid latch Address → RD_ISSUE.
  - RD_ISSUE: when Busy=0, pulse RdEn → RD_WAIT. Otherwise hold.
  - RD_WAIT: on Rd_valid → IDLE.
  - OP_A: on Rx_valid write byte to Address=0 (WrEn pulse) → OP_B.
  - OP_B: on Rx_valid write byte to Address=1 (WrEn pulse) → FUN.
  - FUN: on Rx_valid latch ALU_FUN=Rx_Data[3:0] → ALU_ISSUE.
  - ALU_ISSUE: when Busy=0, set CLK_EN=1 and pulse ALU_EN → ALU_WAIT.
  - ALU_WAIT: on ALU_out_valid, CLK_EN=0 → IDLE.
- Timeout: the counter clears on entering RD_WAIT/ALU_WAIT and increments each wait cycle. Reaching timeout → Err pulse, CLK_EN=0, → IDLE.
- Rx_valid arriving in RD_ISSUE, RD_WAIT, ALU_ISSUE or ALU_WAIT: byte dropped, Err pulse, state unchanged.
- Rd_valid/ALU_out_valid outside its wait state: ignored.
- Rd_valid in the same cycle as a timeout expiry: completion wins, no Err.
- Address, WrData and ALU_FUN hold their last values between commands. WrEn, RdEn, ALU_EN and Err are never high for more than one cycle.

Test Plan:
- Write frame: send 0xAA, 0x05, 0x3C (Busy=0) → exactly one WrEn pulse with Address=5, WrData=0x3C, one cycle after the 0x3C byte; state returns to IDLE.
- Read with Busy stall: send 0xBB, 0x07 with Busy=1 for 10 cycles → RdEn stays low while Busy is high. RdEn pulses once with Address=7 the cycle after Busy falls. Rd_valid 3 cycles later returns the state to IDLE with no Err.
- ALU with operands: send 0xCC, 0x12, 0x34, 0x01 → WrEn pulses at Address=0 (0x12) and Address=1 (0x34). Then ALU_FUN=1, ALU_EN pulses once, and CLK_EN is high from the ALU_EN cycle until ALU_out_valid.
- ALU without operands: send 0xDD, 0x0A → no WrEn, one ALU_EN pulse with ALU_FUN=0xA.
- Errors:
  - Send 0x55 in IDLE → Err pulse, no strobes.
  - Send 0xBB, 0x02 and withhold Rd_valid → Err exactly timeout cycles after entering RD_WAIT, then IDLE. A following 0xAA frame works normally.
  - Send a byte during ALU_WAIT → Err pulse, ALU_WAIT held.
- Reset mid-frame: after 0xCC, 0x12, assert Reset → all outputs 0 immediately. After release, a stray 0x34 produces Err and no WrEn.
